decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters: none; widths fixed to RV32I.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 flush  in  1  branch redirect; discards all held and arriving instructions.
REQ-005 in_pc  in  32  PC of offered instruction from fetch.
REQ-006 in_instr  in  32  raw instruction word from fetch.
REQ-007 in_valid  in  1  fetch offers in_pc/in_instr.
REQ-008 in_ready  out  1  stage accepts; transfer when in_valid&&in_ready.
REQ-009 out_valid  out  1  decoded bundle valid.
REQ-010 out_ready  in  1  execute accepts; transfer when out_valid&&out_ready.
REQ-011 out_pc  out  32  PC of decoded instruction.
REQ-012 out_op  out  4  class: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OPIMM, 8 OP, 9 MISC_MEM, 10 SYSTEM, 15 ILLEGAL.
REQ-013 out_rd, out_rs1, out_rs2  out  5 each  register indices, instr[11:7], [19:15], [24:20].
REQ-014 out_funct3  out  3  instr[14:12]; out_funct7_b5  out  1  instr[30].
REQ-015 out_imm  out  32  sign-extended immediate per format.
REQ-016 out_rd_we  out  1  destination write enable.
REQ-017 out_illegal  out  1  instruction is illegal (out_op==15).

Function
REQ-018 Decode is combinational on in_instr; results are registered at acceptance; latency accept-to-out_valid is exactly 1 cycle.
REQ-019 Immediates: I = sext(instr[31:20]); S = sext({[31:25],[11:7]}); B = sext({[31],[7],[30:25],[11:8],0}); U = {[31:12],12'b0}; J = sext({[31],[19:12],[20],[30:21],0}); 0 for OP, ILLEGAL.
REQ-020 Illegal when: instr[1:0]!=2'b11; unknown opcode; JALR funct3!=0; BRANCH funct3 in {2,3}; LOAD funct3 in {3,6,7}; STORE funct3>=3; OP funct7 not 0x00/0x20, or 0x20 with funct3 not 0/5; OPIMM funct3=1 with funct7!=0, funct3=5 with funct7 not 0x00/0x20.
REQ-021 out_rd_we = 1 for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP, SYSTEM when rd!=0; else 0; always 0 when illegal.
REQ-022 Held bundle SHALL remain stable while out_valid&&!out_ready.
REQ-023 Order preserved; no instruction dropped or duplicated except by flush or reset.
REQ-024 flush high: all valid state cleared next edge; instruction offered that cycle is discarded; out_valid=0 the following cycle.
REQ-025 flush has priority over simultaneous accept, output transfer and buffer moves.
REQ-026 Simultaneous input accept and output transfer with one entry held: new bundle replaces output register, no bubble.

Reset
REQ-027 On rst_n low, asynchronously: out_valid=0, skid entry invalid, in_ready=1 after reset release (0 during reset permitted only via combinational dependence); data registers SHALL be reset to 0.
REQ-028 Reset mid-transfer discards all held instructions; first accept after release proceeds normally.

Configuration
REQ-029 Macro DECODE_SKID_EN defined: one output register plus one skid register; in_ready is a register output equal to !skid_valid; with out_ready low, two instructions are absorbed before in_ready falls; skid drains to output register on first out_ready.
REQ-030 DECODE_SKID_EN undefined: single output register; in_ready = !out_valid || out_ready (combinational); behaviour REQ-018..026 otherwise identical.

Verification
REQ-031 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_op=7, rd=1, rs1=0, imm=0x00000005, rd_we=1, illegal=0.
REQ-032 0xFE208EE3 (beq x1,x2,-4) -> out_op=4, rs1=1, rs2=2, imm=0xFFFFFFFC, rd_we=0; 0x123452B7 (lui x5,0x12345) -> op=0, rd=5, imm=0x12345000.
REQ-033 0x00000000 and 0x02001033 (funct7=0x01 OP) -> out_op=15, illegal=1, rd_we=0, imm=0.
REQ-034 Stream of PCs 0x00,0x04,0x08,0x0C, out_ready low 3 cycles -> with DECODE_SKID_EN in_ready falls after 2 accepts; on release outputs appear in order 0x00..0x0C, none lost.
REQ-035 flush asserted while one bundle held and in_valid=1 at PC 0x10 -> next cycle out_valid=0, PC 0x10 never emitted; next accept (PC 0x80) emitted one cycle later.
REQ-036 rst_n pulsed low with two entries held -> out_valid=0 immediately; after release first accepted instruction emitted with 1-cycle latency.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word, registered bundle with valid/ready handshake.
// Define DECODE_SKID_EN to add a skid register and make in_ready a registered output.
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [3:0]  out_op,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [2:0]  out_funct3,
    output logic        out_funct7_b5,
    output logic [31:0] out_imm,
    output logic        out_rd_we,
    output logic        out_illegal
);

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7_b5;
        logic [31:0] imm;
        logic        rd_we;
        logic        illegal;
    } bundle_t;

    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [3:0]  w_op;
    logic [31:0] w_imm;
    logic        w_we_class;
    bundle_t     w_dec;

    assign w_f3    = in_instr[14:12];
    assign w_f7    = in_instr[31:25];
    assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u = {in_instr[31:12], 12'b0};
    assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // Op/imm/write-enable are only set on a legal decode, so illegal words fall through to 15/0/0.
    always_comb begin
        w_op       = 4'd15;
        w_imm      = 32'd0;
        w_we_class = 1'b0;
        if (in_instr[1:0] == 2'b11) begin
            case (in_instr[6:2])
                5'b01101: begin w_op = 4'd0; w_imm = w_imm_u; w_we_class = 1'b1; end
                5'b00101: begin w_op = 4'd1; w_imm = w_imm_u; w_we_class = 1'b1; end
                5'b11011: begin w_op = 4'd2; w_imm = w_imm_j; w_we_class = 1'b1; end
                5'b11001: if (w_f3 == 3'd0) begin
                    w_op = 4'd3; w_imm = w_imm_i; w_we_class = 1'b1;
                end
                5'b11000: if (w_f3 != 3'd2 && w_f3 != 3'd3) begin
                    w_op = 4'd4; w_imm = w_imm_b;
                end
                5'b00000: if (w_f3 != 3'd3 && w_f3 != 3'd6 && w_f3 != 3'd7) begin
                    w_op = 4'd5; w_imm = w_imm_i; w_we_class = 1'b1;
                end
                5'b01000: if (w_f3 < 3'd3) begin
                    w_op = 4'd6; w_imm = w_imm_s;
                end
                5'b00100: if ((w_f3 == 3'd1) ? (w_f7 == 7'h00) :
                              (w_f3 == 3'd5) ? (w_f7 == 7'h00 || w_f7 == 7'h20) : 1'b1) begin
                    w_op = 4'd7; w_imm = w_imm_i; w_we_class = 1'b1;
                end
                5'b01100: if (w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5))) begin
                    w_op = 4'd8; w_we_class = 1'b1;
                end
                5'b00011: begin w_op = 4'd9;  w_imm = w_imm_i; end
                5'b11100: begin w_op = 4'd10; w_imm = w_imm_i; w_we_class = 1'b1; end
                default: ;
            endcase
        end
    end

    assign w_dec.pc        = in_pc;
    assign w_dec.op        = w_op;
    assign w_dec.rd        = in_instr[11:7];
    assign w_dec.rs1       = in_instr[19:15];
    assign w_dec.rs2       = in_instr[24:20];
    assign w_dec.funct3    = w_f3;
    assign w_dec.funct7_b5 = in_instr[30];
    assign w_dec.imm       = w_imm;
    assign w_dec.rd_we     = w_we_class && (in_instr[11:7] != 5'd0);
    assign w_dec.illegal   = (w_op == 4'd15);

    bundle_t r_out;
    logic    r_out_valid;

`ifdef DECODE_SKID_EN
    bundle_t r_skid;
    logic    r_skid_valid;
    logic    r_in_ready;
    logic    w_accept;

    assign in_ready = r_in_ready;
    assign w_accept = in_valid && r_in_ready;

    // r_in_ready always tracks !r_skid_valid; the skid only fills while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (!r_out_valid) begin
            if (w_accept) begin
                r_out       <= w_dec;
                r_out_valid <= 1'b1;
            end
        end else if (out_ready) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_accept) begin
                r_out <= w_dec;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end
`else
    assign in_ready = !r_out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            r_out       <= w_dec;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    assign out_valid     = r_out_valid;
    assign out_pc        = r_out.pc;
    assign out_op        = r_out.op;
    assign out_rd        = r_out.rd;
    assign out_rs1       = r_out.rs1;
    assign out_rs2       = r_out.rs2;
    assign out_funct3    = r_out.funct3;
    assign out_funct7_b5 = r_out.funct7_b5;
    assign out_imm       = r_out.imm;
    assign out_rd_we     = r_out.rd_we;
    assign out_illegal   = r_out.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed RV32I cases plus random traffic against a queue-based reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        in_ready, out_valid, out_funct7_b5, out_rd_we, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [3:0]  out_op;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_pc(in_pc), .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
        .out_funct7_b5(out_funct7_b5), .out_imm(out_imm), .out_rd_we(out_rd_we),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        f7b5;
        logic [31:0] imm;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference decode built from the ISA rules with plain arithmetic on field values.
    function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] i);
        exp_t e;
        int opc, f3, f7, cls, imm, imm_i, imm_s, imm_b, imm_u, imm_j;
        bit ok, wr;
        opc   = int'(i[6:0]);
        f3    = int'(i[14:12]);
        f7    = int'(i[31:25]);
        imm_i = $signed(i) >>> 20;
        imm_s = (imm_i & ~31) | int'(i[11:7]);
        imm_b = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        imm_u = int'(i & 32'hFFFFF000);
        imm_j = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        ok = 1; wr = 0; cls = 15; imm = 0;
        case (opc)
            'h37: begin cls = 0;  imm = imm_u; wr = 1; end
            'h17: begin cls = 1;  imm = imm_u; wr = 1; end
            'h6F: begin cls = 2;  imm = imm_j; wr = 1; end
            'h67: begin cls = 3;  imm = imm_i; wr = 1; ok = (f3 == 0); end
            'h63: begin cls = 4;  imm = imm_b; ok = !(f3 == 2 || f3 == 3); end
            'h03: begin cls = 5;  imm = imm_i; wr = 1; ok = !(f3 == 3 || f3 == 6 || f3 == 7); end
            'h23: begin cls = 6;  imm = imm_s; ok = (f3 < 3); end
            'h13: begin
                cls = 7; imm = imm_i; wr = 1;
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) ok = (f7 == 0 || f7 == 32);
            end
            'h33: begin
                cls = 8; imm = 0; wr = 1;
                ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
            end
            'h0F: begin cls = 9;  imm = imm_i; end
            'h73: begin cls = 10; imm = imm_i; wr = 1; end
            default: ok = 0;
        endcase
        if (!ok) begin cls = 15; imm = 0; wr = 0; end
        e.pc   = pc;
        e.op   = cls[3:0];
        e.rd   = i[11:7];
        e.rs1  = i[19:15];
        e.rs2  = i[24:20];
        e.f3   = i[14:12];
        e.f7b5 = i[30];
        e.imm  = imm;
        e.we   = wr && (i[11:7] != 0);
        e.ill  = !ok;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 13);
        case (k)
            0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;  3: w[6:0] = 7'h67;
            4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;  6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;
            8: w[6:0] = 7'h33;  9: w[6:0] = 7'h0F;  10: w[6:0] = 7'h73; 11: w[6:0] = 7'h13;
            default: ;
        endcase
        k = $urandom_range(0, 2);
        if (k == 0) w[31:25] = 7'h00;
        if (k == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    // Compare the DUT against the model at the negedge, then advance the model for the coming edge.
    task automatic monitor();
        exp_t h;
        logic exp_rdy;
        chk("out_valid", out_valid, (q.size() != 0));
`ifdef DECODE_SKID_EN
        exp_rdy = (q.size() < 2);
`else
        exp_rdy = (q.size() == 0) || out_ready;
`endif
        chk("in_ready", in_ready, exp_rdy);
        if (out_valid && q.size() != 0) begin
            h = q[0];
            chk("pc", out_pc, h.pc);
            chk("op", out_op, h.op);
            chk("rd", out_rd, h.rd);
            chk("rs1", out_rs1, h.rs1);
            chk("rs2", out_rs2, h.rs2);
            chk("funct3", out_funct3, h.f3);
            chk("funct7_b5", out_funct7_b5, h.f7b5);
            chk("imm", out_imm, h.imm);
            chk("rd_we", out_rd_we, h.we);
            chk("illegal", out_illegal, h.ill);
        end
        if (flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(ref_decode(in_pc, in_instr));
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl, output logic acc);
        in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
        @(negedge clk);
        acc = in_valid && in_ready && !flush;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic a;
        int n = 0;
        while (q.size() != 0 && n < 10) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
            n++;
        end
        chk("drain_timeout", q.size(), 0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
    endtask

    task automatic directed(input logic [31:0] ins, input logic [3:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                            input logic we, input logic ill);
        logic a;
        cycle(1'b1, 32'h100, ins, 1'b1, 1'b0, a);
        chk("dir_valid", out_valid, 1'b1);
        chk("dir_op", out_op, op);
        chk("dir_rd", out_rd, rd);
        chk("dir_rs1", out_rs1, rs1);
        chk("dir_rs2", out_rs2, rs2);
        chk("dir_imm", out_imm, imm);
        chk("dir_rd_we", out_rd_we, we);
        chk("dir_illegal", out_illegal, ill);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        int idx, budget;

        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_imm", out_imm, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1'b1);

        directed(32'h00500093, 4'd7, 5'd1, 5'd0, 5'd5, 32'h00000005, 1'b1, 1'b0);
        directed(32'hFE208EE3, 4'd4, 5'd29, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 1'b0);
        directed(32'h123452B7, 4'd0, 5'd5, 5'd8, 5'd3, 32'h12345000, 1'b1, 1'b0);
        directed(32'h00000000, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
        directed(32'h02001033, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
        drain();

        // Stalled stream of four PCs, then release.
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, idx * 4, 32'h00000013 | ((idx + 1) << 7), 1'b0, 1'b0, a);
            if (a) idx++;
        end
`ifdef DECODE_SKID_EN
        chk("skid_absorbed", idx, 2);
`else
        chk("single_absorbed", idx, 1);
`endif
        chk("stall_in_ready", in_ready, 1'b0);
        budget = 0;
        while (idx < 4 && budget < 20) begin
            cycle(1'b1, idx * 4, 32'h00000013 | ((idx + 1) << 7), 1'b1, 1'b0, a);
            if (a) idx++;
            budget++;
        end
        chk("stream_accepts", idx, 4);
        drain();

        // Flush with one bundle held and an instruction on offer.
        cycle(1'b1, 32'h40, 32'h00100113, 1'b0, 1'b0, a);
        cycle(1'b1, 32'h10, 32'h00200193, 1'b1, 1'b1, a);
        chk("flush_out_valid", out_valid, 1'b0);
        cycle(1'b1, 32'h80, 32'h00300213, 1'b1, 1'b0, a);
        chk("post_flush_valid", out_valid, 1'b1);
        chk("post_flush_pc", out_pc, 32'h80);
        drain();

        // Reset with entries held.
        cycle(1'b1, 32'h300, 32'h00100113, 1'b0, 1'b0, a);
        cycle(1'b1, 32'h304, 32'h00200193, 1'b0, 1'b0, a);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_pc", out_pc, 32'h0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rel_in_ready", in_ready, 1'b1);
        cycle(1'b1, 32'h200, 32'h00500093, 1'b1, 1'b0, a);
        chk("rel_valid", out_valid, 1'b1);
        chk("rel_pc", out_pc, 32'h200);
        drain();

        for (int c = 0; c < 3000; c++) begin
            cycle($urandom_range(0, 3) != 0, {$urandom_range(0, 32'h3FFF), 2'b00}, rand_instr(),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, a);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
